// File: rtl/dma_ch_xfer.sv
// Per-channel DMA burst engine with a local 2^FIFO_AW FIFO; `DMA_CH_ADDR_INC_EN selects incrementing addresses.
// Latency: en sampled in IDLE -> bus_req next cycle; ack -> GAP then next beat two cycles later, or req_done next cycle.
// Backpressure: a beat holds bus_req/addr/wdata until bus_ack; grants end early on FIFO full/empty or burst limit.
module dma_ch_xfer #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int CNT_W   = 16,
    parameter int BURST   = 4,
    parameter int FIFO_AW = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ch_en,
    input  logic             i_target,
    input  logic [AW-1:0]    i_src_addr,
    input  logic [AW-1:0]    i_dst_addr,
    input  logic [CNT_W-1:0] i_xfer_len,
    input  logic             i_en,
    output logic             o_req_done,
    output logic             o_t0_done,
    output logic             o_fifo_empty,
    output logic             o_fifo_full,
    output logic             o_busy,
    output logic             o_bus_req,
    output logic             o_bus_we,
    output logic [AW-1:0]    o_bus_addr,
    output logic [DW-1:0]    o_bus_wdata,
    input  logic [DW-1:0]    i_bus_rdata,
    input  logic             i_bus_ack,
    input  logic             i_ext_push,
    input  logic [DW-1:0]    i_ext_wdata,
    input  logic             i_ext_pop,
    output logic [DW-1:0]    o_ext_rdata
);

    localparam int DEPTH  = 1 << FIFO_AW;
    localparam int BEAT_W = $clog2(BURST + 1);
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(DEPTH);
    localparam logic [BEAT_W-1:0] BURST_C = BEAT_W'(BURST);

    typedef enum logic [1:0] {S_IDLE, S_BEAT, S_GAP, S_DONE} state_t;

    state_t              r_state;
    logic                r_bus_req;
    logic                r_bus_we;
    logic [DW-1:0]       r_bus_wdata;
    logic                r_req_done;
    logic [BEAT_W-1:0]   r_beats;
    logic                r_en_block;

    logic                r_ch_en_d;
    logic [AW-1:0]       r_cur_addr;
    logic [CNT_W-1:0]    r_remain;
    logic                r_t0_done;

    logic [DW-1:0]       r_mem [DEPTH];
    logic [FIFO_AW-1:0]  r_wptr;
    logic [FIFO_AW-1:0]  r_rptr;
    logic [FIFO_AW:0]    r_count;
    logic                r_fifo_empty;
    logic                r_fifo_full;
    logic [DW-1:0]       r_ext_rdata;

    logic                w_ch_start;
    logic                w_ack;
    logic                w_bus_push;
    logic                w_bus_pop;
    logic                w_ext_push;
    logic                w_ext_pop;
    logic                w_push;
    logic                w_pop;
    logic [DW-1:0]       w_push_dat;
    logic [DW-1:0]       w_head;
    logic [FIFO_AW:0]    w_count_nxt;
    logic [CNT_W-1:0]    w_remain_nxt;
    logic [BEAT_W-1:0]   w_beats_nxt;
    logic                w_work;
    logic                w_more;
    logic                w_start;

    assign w_ch_start   = i_ch_en & ~r_ch_en_d;
    assign w_ack        = (r_state == S_BEAT) & i_bus_ack;
    assign w_bus_push   = w_ack & ~r_bus_we;
    assign w_bus_pop    = w_ack & r_bus_we;
    // Peripheral side only gets the FIFO port that matches the configured direction.
    assign w_ext_push   = i_ext_push & i_target & ~r_fifo_full & ~w_bus_push;
    assign w_ext_pop    = i_ext_pop & ~i_target & ~r_fifo_empty & ~w_bus_pop;
    assign w_push       = w_bus_push | w_ext_push;
    assign w_pop        = w_bus_pop | w_ext_pop;
    assign w_push_dat   = w_bus_push ? i_bus_rdata : i_ext_wdata;
    assign w_head       = r_mem[r_rptr];
    assign w_count_nxt  = r_count + (FIFO_AW+1)'(w_push) - (FIFO_AW+1)'(w_pop);
    assign w_remain_nxt = (r_remain != '0) ? r_remain - CNT_W'(1) : '0;
    assign w_beats_nxt  = r_beats + BEAT_W'(1);

    assign w_work  = i_target ? ~r_fifo_empty : (~r_t0_done & ~r_fifo_full);
    assign w_start = i_en & i_ch_en & ~r_en_block;
    assign w_more  = (w_beats_nxt < BURST_C) &&
                     (r_bus_we ? (w_count_nxt != '0)
                               : ((w_remain_nxt != '0) && (w_count_nxt != DEPTH_C)));

    // r_en_block stops the still-high grant after DONE from starting a second burst.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= S_IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_wdata <= '0;
            r_req_done  <= 1'b0;
            r_beats     <= '0;
            r_en_block  <= 1'b0;
        end else begin
            r_req_done <= 1'b0;
            if (!i_en)
                r_en_block <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        if (w_work) begin
                            r_state     <= S_BEAT;
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= i_target;
                            r_bus_wdata <= i_target ? w_head : '0;
                        end else begin
                            r_state    <= S_DONE;
                            r_req_done <= 1'b1;
                        end
                    end
                end
                S_BEAT: begin
                    if (i_bus_ack) begin
                        r_bus_req <= 1'b0;
                        r_beats   <= w_beats_nxt;
                        if (!i_en) begin
                            r_state <= S_IDLE;
                            r_beats <= '0;
                        end else if (w_more) begin
                            r_state <= S_GAP;
                        end else begin
                            r_state    <= S_DONE;
                            r_req_done <= 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (!i_en) begin
                        r_state <= S_IDLE;
                        r_beats <= '0;
                    end else if (w_work) begin
                        r_state     <= S_BEAT;
                        r_bus_req   <= 1'b1;
                        r_bus_wdata <= r_bus_we ? w_head : '0;
                    end else begin
                        r_state    <= S_DONE;
                        r_req_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_beats    <= '0;
                    r_en_block <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_ch_en_d <= 1'b0;
            r_remain  <= '0;
            r_t0_done <= 1'b0;
        end else begin
            r_ch_en_d <= i_ch_en;
            if (w_ch_start) begin
                r_remain  <= i_xfer_len;
                r_t0_done <= (i_xfer_len == '0);
            end else if (!i_ch_en) begin
                r_t0_done <= 1'b0;
            end else if (w_bus_push) begin
                r_remain <= w_remain_nxt;
                if (w_remain_nxt == '0)
                    r_t0_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cur_addr <= '0;
        end else if (w_ch_start) begin
            r_cur_addr <= i_target ? i_dst_addr : i_src_addr;
`ifdef DMA_CH_ADDR_INC_EN
        end else if (w_ack) begin
            r_cur_addr <= r_cur_addr + AW'(DW / 8);
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wptr] <= w_push_dat;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_fifo_empty <= 1'b1;
            r_fifo_full  <= 1'b0;
            r_ext_rdata  <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + FIFO_AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + FIFO_AW'(1);
            if (w_ext_pop)
                r_ext_rdata <= w_head;
            r_count      <= w_count_nxt;
            r_fifo_empty <= (w_count_nxt == '0);
            r_fifo_full  <= (w_count_nxt == DEPTH_C);
        end
    end

    assign o_req_done   = r_req_done;
    assign o_t0_done    = r_t0_done;
    assign o_fifo_empty = r_fifo_empty;
    assign o_fifo_full  = r_fifo_full;
    assign o_busy       = (r_state != S_IDLE);
    assign o_bus_req    = r_bus_req;
    assign o_bus_we     = r_bus_we;
    assign o_bus_addr   = r_cur_addr;
    assign o_bus_wdata  = r_bus_wdata;
    assign o_ext_rdata  = r_ext_rdata;

endmodule
